kvs_vs_regex_requester: RTL
===========================

# kvs_vs_regex_requester

Drives the value-search regex array from the KVS value pipeline and collects its per-value match decisions. Values arrive as 512-bit word streams with per-value metadata. The block forwards the words to the regex array input port and inserts configuration words only when the array is quiescent. It pairs each returned 1-bit decision with the metadata of the value that produced it, in strict issue order.

## Interface
- `META_WIDTH`, 64: per-value metadata width (key handle, opcode, etc.).
- `OUTSTANDING_DEPTH`, 32: maximum number of values issued whose decision has not yet returned. Power of two.
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `value_data` in 512: value word. `value_valid` in 1. `value_last` in 1: last word of the value. `value_ready` out 1.
- `value_meta` in META_WIDTH: metadata, sampled on the first accepted word of each value.
- `cfg_data` in 512, `cfg_valid` in 1, `cfg_ready` out 1: regex configuration word; bit 511 means broadcast.
- `rx_input_data` out 512, `rx_input_valid` out 1, `rx_input_last` out 1, `rx_input_ready` in 1: to the regex array data port.
- `rx_config_data` out 512, `rx_config_valid` out 1, `rx_config_ready` in 1: to the regex array config port.
- `rx_found_loc` in 1, `rx_found_valid` in 1, `rx_found_ready` out 1: decisions from the array, in issue order.
- `res_meta` out META_WIDTH, `res_match` out 1, `res_valid` out 1, `res_ready` in 1: paired result.
- `outstanding` out clog2(OUTSTANDING_DEPTH)+1: current in-flight count.
- `err_orphan` out 1: sticky; set when a decision arrives while no metadata is pending.

## Operation
- FSM states:
  - IDLE: no value is partially sent.
  - STREAM: between the first and the last word of a value.
  - CFG_DRAIN: a config word is waiting for outstanding to reach 0.
  - CFG_SEND: the config word is presented to the array.
- IDLE behaviour:
  - If `cfg_valid` is high, go to CFG_DRAIN. Config has priority over a new value.
  - Otherwise accept a value word when `value_valid` && `rx_input_ready` && the metadata FIFO is not full.
  - On that first-word handshake, push `value_meta` into the metadata FIFO.
  - If the word is not last, go to STREAM. If it is last (single-word value), stay in IDLE.
- STREAM behaviour:
  - Pass words through with `value_ready` = `rx_input_ready`.
  - Return to IDLE on the handshake of the last word.
  - A pending `cfg_valid` waits; it never interrupts a value.
- CFG_DRAIN: value input is blocked (`value_ready`=0). Go to CFG_SEND when `outstanding`==0.
- CFG_SEND: `rx_config_valid`=1. On `rx_config_ready`, raise `cfg_ready` for that same cycle (pass-through handshake) and go to IDLE.
- Data path is combinational pass-through: `rx_input_data` = `value_data`, `rx_input_last` = `value_last`, `rx_input_valid` = `value_valid` && state permits && (not first word, or FIFO not full).
- `outstanding`: +1 on each first-word push, −1 on each result pop. Both in one cycle leaves it unchanged.
- Result path:
  - `rx_found_ready` is high when the output register is empty or being drained by `res_ready`, and the FIFO is non-empty.
  - On the `rx_found` handshake, pop the FIFO head into `res_meta`/`res_match` and set `res_valid`.
- Orphan decision (`rx_found_valid` with the FIFO empty): drop it with `rx_found_ready`=1, set `err_orphan`, leave the counter unchanged.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty, `outstanding`=0.
  - All valid/ready outputs 0 except `value_ready`, which follows its combinational rule.
  - `res_meta`/`res_match` = 0, `err_orphan` = 0.
- Value to array latency: 0 cycles. Decision to `res_valid` latency: 1 cycle.
- Full throughput: one value word and one result per cycle, including a simultaneous FIFO push and pop when full.
- FIFO full: the first word of a new value is stalled. Words inside an already-started value still flow.
- `outstanding` == OUTSTANDING_DEPTH is reachable. The counter must not wrap.
- A value's first word arriving in the same cycle as `cfg_valid` rises: config wins and the word is not accepted.
- Reset asserted mid-value: the partial value is discarded and the FSM returns to IDLE. Upstream must also be reset.

## Structure
- Shared package: FSM state encoding, `VALUE_W`=512, and the bit position of the config broadcast flag (511).
- One sub-module: `kvs_vs_meta_fifo`, a synchronous FIFO holding META_WIDTH-wide entries with full/empty flags and first-word fall-through.

## Test plan
- Three single-word values with meta 0x1, 0x2, 0x3; decisions 1, 0, 1 → results (0x1,1), (0x2,0), (0x3,1) in order, with `outstanding` returning to 0.
- One 4-word value while `cfg_valid` rises at word 2 → all 4 words are sent first; config is issued only after its decision returns; `rx_config_valid` is never high while `outstanding`≠0.
- 32 values issued with no decisions → the 33rd first word is stalled and `outstanding`=32. Then one decision with `res_ready`=1 in the same cycle as a push → count stays 32.
- `res_ready` held low for 5 cycles with decisions pending → `rx_found_ready`=0 after the register fills; no result is lost or duplicated.
- `rx_found_valid` pulse with nothing outstanding → `err_orphan`=1 and stays 1; no `res_valid`.
- Reset asserted in STREAM after 2 of 4 words → next cycle FSM=IDLE, `outstanding`=0, all valid outputs 0.

Source files
------------

// File: rtl/kvs_vs_regex_requester_pkg.sv
// Shared definitions for the KVS value-search regex requester.
//   VALUE_W        : width of one value / config word
//   CFG_BCAST_BIT  : bit of a config word that marks it as a broadcast
//   state_e        : requester FSM state encoding
package kvs_vs_regex_requester_pkg;

    localparam int unsigned VALUE_W       = 512;
    localparam int unsigned CFG_BCAST_BIT = 511;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,  // no value partially sent
        StStream   = 2'd1,  // between first and last word of a value
        StCfgDrain = 2'd2,  // config pending, waiting for in-flight values to resolve
        StCfgSend  = 2'd3   // config word presented to the array
    } state_e;

endpackage

// File: rtl/kvs_vs_meta_fifo.sv
// Synchronous first-word-fall-through FIFO for per-value metadata.
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_push, i_wdata    : write strobe and entry (caller keeps push off when full, unless popping)
//   i_pop              : read strobe (caller keeps pop off when empty)
//   o_rdata            : head entry, valid whenever o_empty is low
//   o_full, o_empty    : occupancy flags
//   o_count            : number of stored entries (0..DEPTH)
module kvs_vs_meta_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/kvs_vs_regex_requester.sv
// Feeds KVS value words to the regex array and pairs each returned decision with the
// metadata of the value that produced it, in issue order. Config words are only issued
// once every in-flight value has returned its decision.
// Ports:
//   i_clk, i_rst                                   : clock, asynchronous active-high reset
//   i_value_*/o_value_ready                        : value word stream + per-value metadata
//   i_cfg_data/i_cfg_valid/o_cfg_ready             : regex config word (bit 511 = broadcast)
//   o_rx_input_*/i_rx_input_ready                  : array data port (combinational pass-through)
//   o_rx_config_*/i_rx_config_ready                : array config port
//   i_rx_found_loc/i_rx_found_valid/o_rx_found_ready : per-value decision from the array
//   o_res_meta/o_res_match/o_res_valid/i_res_ready : paired result
//   o_outstanding                                  : values issued without a returned decision
//   o_err_orphan                                   : sticky, decision seen with nothing pending
module kvs_vs_regex_requester
    import kvs_vs_regex_requester_pkg::*;
#(
    parameter int unsigned META_WIDTH        = 64,
    parameter int unsigned OUTSTANDING_DEPTH = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [VALUE_W-1:0]                   i_value_data,
    input  logic                                 i_value_valid,
    input  logic                                 i_value_last,
    output logic                                 o_value_ready,
    input  logic [META_WIDTH-1:0]                i_value_meta,
    input  logic [VALUE_W-1:0]                   i_cfg_data,
    input  logic                                 i_cfg_valid,
    output logic                                 o_cfg_ready,
    output logic [VALUE_W-1:0]                   o_rx_input_data,
    output logic                                 o_rx_input_valid,
    output logic                                 o_rx_input_last,
    input  logic                                 i_rx_input_ready,
    output logic [VALUE_W-1:0]                   o_rx_config_data,
    output logic                                 o_rx_config_valid,
    input  logic                                 i_rx_config_ready,
    input  logic                                 i_rx_found_loc,
    input  logic                                 i_rx_found_valid,
    output logic                                 o_rx_found_ready,
    output logic [META_WIDTH-1:0]                o_res_meta,
    output logic                                 o_res_match,
    output logic                                 o_res_valid,
    input  logic                                 i_res_ready,
    output logic [$clog2(OUTSTANDING_DEPTH):0]   o_outstanding,
    output logic                                 o_err_orphan
);

    localparam int unsigned CW = $clog2(OUTSTANDING_DEPTH) + 1;

    state_e                r_state;
    logic                  r_cfg_valid;
    logic                  r_res_valid;
    logic                  r_res_match;
    logic [META_WIDTH-1:0] r_res_meta;
    logic                  r_err_orphan;

    logic                  w_full;
    logic                  w_empty;
    logic [META_WIDTH-1:0] w_head;
    logic [CW-1:0]         w_count;
    logic                  w_out_free;
    logic                  w_pop;
    logic                  w_orphan;
    logic                  w_found_ready;
    logic                  w_can_push;
    logic                  w_word_ok;
    logic                  w_in_hs;
    logic                  w_push;

    always_comb begin
        w_out_free    = !r_res_valid || i_res_ready;
        w_pop         = i_rx_found_valid && !w_empty && w_out_free;
        w_orphan      = i_rx_found_valid && w_empty;
        // Orphans are swallowed; ready only tracks valid so it idles low.
        w_found_ready = w_empty ? i_rx_found_valid : w_out_free;
        // A full FIFO still takes a new entry when the head leaves in the same cycle.
        w_can_push    = !w_full || w_pop;

        w_word_ok = 1'b0;
        unique case (r_state)
            StIdle:     w_word_ok = !i_cfg_valid && w_can_push;
            StStream:   w_word_ok = 1'b1;
            StCfgDrain: w_word_ok = 1'b0;
            StCfgSend:  w_word_ok = 1'b0;
            default:    w_word_ok = 1'b0;
        endcase

        w_in_hs = i_value_valid && w_word_ok && i_rx_input_ready;
        w_push  = w_in_hs && (r_state == StIdle);
    end

    kvs_vs_meta_fifo #(
        .WIDTH (META_WIDTH),
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_meta_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (i_value_meta),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cfg_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_cfg_valid) begin
                        r_state <= StCfgDrain;
                    end else if (w_in_hs && !i_value_last) begin
                        r_state <= StStream;
                    end
                end
                StStream: begin
                    if (w_in_hs && i_value_last) begin
                        r_state <= StIdle;
                    end
                end
                StCfgDrain: begin
                    if (w_count == '0) begin
                        r_state     <= StCfgSend;
                        r_cfg_valid <= 1'b1;
                    end
                end
                StCfgSend: begin
                    if (i_rx_config_ready) begin
                        r_state     <= StIdle;
                        r_cfg_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_cfg_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_valid  <= 1'b0;
            r_res_meta   <= '0;
            r_res_match  <= 1'b0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_pop) begin
                r_res_valid <= 1'b1;
                r_res_meta  <= w_head;
                r_res_match <= i_rx_found_loc;
            end else if (i_res_ready) begin
                r_res_valid <= 1'b0;
            end
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign o_value_ready     = w_word_ok && i_rx_input_ready;
    assign o_rx_input_data   = i_value_data;
    assign o_rx_input_last   = i_value_last;
    assign o_rx_input_valid  = i_value_valid && w_word_ok;
    assign o_rx_config_data  = i_cfg_data;
    assign o_rx_config_valid = r_cfg_valid;
    assign o_cfg_ready       = r_cfg_valid && i_rx_config_ready;
    assign o_rx_found_ready  = w_found_ready;
    assign o_res_meta        = r_res_meta;
    assign o_res_match       = r_res_match;
    assign o_res_valid       = r_res_valid;
    assign o_outstanding     = w_count;
    assign o_err_orphan      = r_err_orphan;

endmodule
